// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding and
// default sizing.
package fetch_pkg;

    localparam int DEFAULT_AW = 16;
    localparam int DEFAULT_DW = 16;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        FETCH   = 2'b01,
        DELIVER = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/MUX21.sv
// One-bit two-to-one selector cell: Y follows D1 when S=0, D2 when S=1.
module MUX21 (
    input  logic D1,
    input  logic D2,
    input  logic S,
    output logic Y
);

    assign Y = S ? D2 : D1;

endmodule

// File: rtl/pc_mux_n.sv
// N-bit two-to-one selector assembled bit by bit from MUX21 cells.
module pc_mux_n #(
    parameter int N = 16
) (
    input  logic [N-1:0] D1,
    input  logic [N-1:0] D2,
    input  logic         S,
    output logic [N-1:0] Y
);

    // One MUX21 per bit, all sharing the same select.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            MUX21 u_mux (
                .D1(D1[gi]),
                .D2(D2[gi]),
                .S (S),
                .Y (Y[gi])
            );
        end
    endgenerate

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests words from instruction
// memory (req/ack) and hands them to decode (valid/ready). Branches from
// execute always win over the sequential increment.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          AW       = DEFAULT_AW,
    parameter int          DW       = DEFAULT_DW,
    parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          BR_TAKEN,
    input  logic [AW-1:0] BR_TARGET,
    output logic          IM_REQ,
    output logic [AW-1:0] IM_ADDR,
    input  logic          IM_ACK,
    input  logic [DW-1:0] IM_DATA,
    output logic          IR_VALID,
    output logic [DW-1:0] IR,
    output logic [AW-1:0] IR_PC,
    input  logic          IR_READY
);

    fetch_state_t  state_reg, state_next;
    logic [AW-1:0] pc_reg, pc_next;
    logic [AW-1:0] ir_pc_reg, ir_pc_next;
    logic [AW-1:0] br_save_reg, br_save_next;
    logic [DW-1:0] ir_reg, ir_next;
    logic          ir_valid_reg, ir_valid_next;
    logic          br_pend_reg, br_pend_next;

    logic [AW-1:0] pc_inc;
    logic [AW-1:0] branch_target;
    logic [AW-1:0] mux_pc;
    logic          branch_sel;

    // Increment wraps naturally at 2^AW.
    assign pc_inc        = pc_reg + AW'(1);
    // A live branch overrides one that was parked while a request was in flight.
    assign branch_target = BR_TAKEN ? BR_TARGET : br_save_reg;
    assign branch_sel    = BR_TAKEN | br_pend_reg;

    pc_mux_n #(
        .N(AW)
    ) u_pc_mux (
        .D1(pc_inc),
        .D2(branch_target),
        .S (branch_sel),
        .Y (mux_pc)
    );

    // State and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= IDLE;
            pc_reg       <= RESET_PC;
            ir_reg       <= '0;
            ir_pc_reg    <= '0;
            ir_valid_reg <= 1'b0;
            br_pend_reg  <= 1'b0;
            br_save_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ir_reg       <= ir_next;
            ir_pc_reg    <= ir_pc_next;
            ir_valid_reg <= ir_valid_next;
            br_pend_reg  <= br_pend_next;
            br_save_reg  <= br_save_next;
        end
    end

    // Next-state and datapath updates; everything holds unless a case moves it.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        ir_next       = ir_reg;
        ir_pc_next    = ir_pc_reg;
        ir_valid_next = ir_valid_reg;
        br_pend_next  = br_pend_reg;
        br_save_next  = br_save_reg;

        case (state_reg)
            IDLE: begin
                state_next = FETCH;
                if (BR_TAKEN) begin
                    pc_next = mux_pc;
                end
            end
            FETCH: begin
                if (IM_ACK) begin
                    // PC only moves on completion so IM_ADDR is stable per request.
                    pc_next      = mux_pc;
                    br_pend_next = 1'b0;
                    if (!branch_sel) begin
                        ir_next       = IM_DATA;
                        ir_pc_next    = pc_reg;
                        ir_valid_next = 1'b1;
                        state_next    = DELIVER;
                    end
                end else if (BR_TAKEN) begin
                    // Park the redirect; the last one before the ack wins.
                    br_pend_next = 1'b1;
                    br_save_next = BR_TARGET;
                end
            end
            DELIVER: begin
                if (BR_TAKEN) begin
                    ir_valid_next = 1'b0;
                    pc_next       = mux_pc;
                    state_next    = FETCH;
                end else if (IR_READY) begin
                    ir_valid_next = 1'b0;
                    state_next    = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign IM_REQ   = (state_reg == FETCH);
    assign IM_ADDR  = pc_reg;
    assign IR_VALID = ir_valid_reg;
    assign IR       = ir_reg;
    assign IR_PC    = ir_pc_reg;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the RISC core: holds the program counter, requests instructions from instruction memory over a req/ack handshake, and presents each fetched word to decode over a valid/ready handshake.
- Next-PC selection (PC+1 versus branch target) is a bus-wide two-to-one selection; its select input is driven by the branch-taken signal from execute.
- Sits between instruction memory and decode.

Parameters:
- AW, 16, address/PC width in bits.
- DW, 16, instruction width in bits.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- CLK  in  1  sole clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- BR_TAKEN  in  1  one-cycle pulse from execute; redirect fetch; select of next-PC mux.
- BR_TARGET  in  AW  redirect address, sampled when BR_TAKEN=1.
- IM_REQ  out  1  instruction-memory request.
- IM_ADDR  out  AW  request address, equal to PC.
- IM_ACK  in  1  memory completion pulse, one cycle.
- IM_DATA  in  DW  instruction word, valid when IM_ACK=1.
- IR_VALID  out  1  instruction available to decode.
- IR  out  DW  instruction register.
- IR_PC  out  AW  address of the instruction in IR.
- IR_READY  in  1  decode accepts IR this cycle.

Behaviour:
- Reset values, asserted asynchronously while RST=1:
  - state=IDLE, PC=RESET_PC, IR=0, IR_PC=0, IR_VALID=0.
  - BR_PEND=0, BR_SAVE=0.
  - IM_REQ=0, IM_ADDR=RESET_PC.
- States: IDLE, FETCH, DELIVER. IM_REQ=1 exactly in FETCH. IM_ADDR=PC always.
- IDLE: entered only from reset; moves to FETCH on the first clock edge after RST deasserts.
- FETCH:
  - PC is held stable until IM_ACK; IM_ADDR never changes while IM_REQ=1.
  - On IM_ACK with no branch (BR_TAKEN=0, BR_PEND=0): IR<=IM_DATA, IR_PC<=PC, IR_VALID<=1, PC<=PC+1, go to DELIVER.
- DELIVER:
  - IM_REQ=0, IR_VALID=1.
  - On IR_READY: IR_VALID<=0, go to FETCH.
  - Fetch-to-fetch spacing is at least 2 cycles plus memory latency.
- PC increment is modulo 2^AW: PC of all ones increments to 0, with no flag.
- Branch handling (branch has priority over increment in every case):
  - BR_TAKEN in IDLE: PC<=BR_TARGET; the transition to FETCH is unchanged.
  - BR_TAKEN in DELIVER: IR_VALID<=0 (flush, even if IR_READY=1 in the same cycle), PC<=BR_TARGET, go to FETCH.
  - BR_TAKEN in FETCH with IM_ACK=0: the request stays outstanding. BR_PEND<=1, BR_SAVE<=BR_TARGET. A later BR_TAKEN before ack overwrites BR_SAVE (last branch wins).
  - IM_ACK in FETCH with BR_PEND=1 and BR_TAKEN=0: IM_DATA discarded, IR_VALID stays 0, PC<=BR_SAVE, BR_PEND<=0, remain in FETCH.
  - IM_ACK in FETCH with BR_TAKEN=1 (BR_PEND either value): IM_DATA discarded, PC<=BR_TARGET, BR_PEND<=0, remain in FETCH.
  - Leaving FETCH for IM_REQ=0 for one cycle is not required; back-to-back requests are legal.
- IM_ACK outside FETCH is ignored.
- IR, IR_PC and IR_VALID stay stable while IR_VALID=1 and IR_READY=0.
- Reset mid-operation: any outstanding request is abandoned and all state returns to reset values immediately. Instruction memory shares RST and drops its pending ack.

Decomposition:
- Shared package fetch_pkg:
  - State encoding constants: IDLE=2'b00, FETCH=2'b01, DELIVER=2'b10.
  - Default AW, DW, RESET_PC.
- Sub-module pc_mux_n, parameter N: N-bit two-to-one selector built from N instances of the existing one-bit MUX21 cell.
  - Used for next-PC selection: D1=PC+1, D2=target, S=branch-select.
  - The target input is itself chosen between BR_TARGET and BR_SAVE according to BR_TAKEN.

Test Plan:
- Reset/start: RST high 3 cycles, then low → IM_REQ=0 during reset; IM_REQ=1, IM_ADDR=0x0000 one cycle after release.
- Sequential fetch, memory ack latency 2, IR_READY=1 → IR_PC sequence 0,1,2,3; IR matches memory words; IR_VALID high exactly 1 cycle per word.
- Decode stall: IR_READY=0 for 5 cycles with IR=0xA5A5 → IR, IR_PC and IR_VALID hold; IM_REQ=0 throughout; next fetch address is IR_PC+1.
- Branch in FETCH before ack: BR_TAKEN with 0x0040, then second BR_TAKEN with 0x0080, then ack → IM_ADDR unchanged until ack; ack data discarded; next IM_ADDR=0x0080.
- Branch in DELIVER with IR_READY=1, target 0x1234 → IR_VALID drops, word not counted as delivered; next IM_ADDR=0x1234.
- Wrap and async reset: RESET_PC=0xFFFF fetch → next IM_ADDR=0x0000; RST asserted mid-FETCH → IM_REQ=0 and PC=RESET_PC before the next clock edge.
